fetch_pc_gen: RTL and testbench
===============================

// Module: fetch_pc_gen
// PURPOSE
//  Parametrised fetch-PC generator for the frontend; supersedes the fixed dual-PC stage.
//  Issues one fetch block of FETCH_WIDTH sequential instruction PCs per transfer to the icache.
//  Uses a valid/ready handshake, fetch-block alignment, branch-prediction redirect and
//  backend flush redirect. Detects misaligned-PC ADEF and stops fetching until the next flush.
// PARAMETERS
//  FETCH_WIDTH  2              instructions per fetch block; legal values 1, 2, 4
//  RESET_PC     32'h1c000000   PC loaded on reset
// PORTS
//  clk                 in   1               clock
//  rst                 in   1               synchronous, active-high reset
//  flush               in   1               backend redirect request
//  flush_pc            in   32              redirect target
//  stall               in   1               backend/IF stall; suppresses requests
//  pred_taken          in   1               BPU: current block predicted taken
//  pred_pc             in   32              BPU predicted target
//  req_valid           out  1               fetch request valid
//  req_ready           in   1               icache accepts request
//  req_pc              out  32              block base PC (= lane 0 PC)
//  lane_pc             out  32*FETCH_WIDTH  lane i PC = req_pc + 4*i, lane i at [32*i+:32]
//  lane_valid          out  FETCH_WIDTH     per-lane valid
//  pc_is_exception     out  1               request carries ADEF
//  pc_exception_cause  out  7               `EXCEPTION_ADEF or `EXCEPTION_NOP (defines.vh)
// BEHAVIOUR
//  - Reset (clk, rst synchronous, active-high): pc=RESET_PC, state=BOOT, req_valid=0,
//    lane_valid=0, pc_is_exception=0, pc_exception_cause=`EXCEPTION_NOP. rst overrides everything.
//  - FSM:
//    - BOOT -> RUN after one cycle.
//    - RUN -> HALT on an accepted request with ADEF.
//    - HALT -> RUN on flush.
//    - Any state -> RUN on flush (except under rst).
//  - Outputs:
//    - req_valid = (state==RUN) & !stall, combinational.
//    - req_pc, lane_pc and lane_valid come from the pc register.
//  - Transfer = req_valid & req_ready. While req_valid=1 and req_ready=0, req_pc and lane_* stay stable.
//  - Alignment, with OFF = pc[log2(FETCH_WIDTH*4)-1:2]:
//    - lane_valid[i] = 1 iff i + OFF < FETCH_WIDTH (lanes past the block end are invalid).
//    - Sequential next PC = {pc block-aligned} + FETCH_WIDTH*4.
//    - FETCH_WIDTH=1: OFF=0, next = pc+4.
//  - ADEF: pc[1:0] != 0 gives pc_is_exception=1, cause=`EXCEPTION_ADEF, lane_valid=1 in lane 0 only.
//    Request still issues; after its transfer the state goes to HALT (req_valid=0).
//  - pc update priority, per clock:
//    1. rst
//    2. flush: pc <= flush_pc. Also applies in a transfer cycle; that block is discarded downstream.
//    3. transfer & pred_taken: pc <= pred_pc.
//    4. transfer: pc <= sequential next.
//    5. otherwise hold.
//  - pred_taken is sampled only in transfer cycles; it is ignored when there is no transfer or when stall=1.
//  - flush while stall=1: pc still loads flush_pc; requests resume when stall drops.
//  - Arithmetic is 32-bit modulo 2^32. FETCH_WIDTH=2 at pc=32'hFFFFFFF8 gives next 32'h00000000.
//  - Misaligned flush_pc/pred_pc is loaded unchanged and raises ADEF when issued.
//  - Outputs are undefined-free in every state. In BOOT and HALT: lane_valid=0 and pc_is_exception=0.
// TESTING
//  1. FETCH_WIDTH=2, release rst, req_ready=1:
//     -> req_valid rises on the 2nd cycle; req_pc 1c000000, 1c000008, 1c000010; lane_valid=2'b11.
//  2. flush_pc=1c000104 (FETCH_WIDTH=2):
//     -> next req_pc=1c000104, lane_valid=2'b01, lane_pc[0]=1c000104.
//     -> then req_pc=1c000108, lane_valid=2'b11.
//  3. req_ready=0 for 3 cycles at 1c000010 -> req_pc held at 1c000010, no advance.
//     stall=1 -> req_valid=0, pc held, and pred_taken=1 is ignored.
//  4. pred_taken=1, pred_pc=1c000200 with transfer -> next req_pc=1c000200.
//     Same cycle with flush=1, flush_pc=1c000040 -> next req_pc=1c000040.
//  5. flush_pc=1c000002:
//     -> req with pc_is_exception=1, cause=`EXCEPTION_ADEF, lane_valid=2'b01.
//     -> after transfer, req_valid=0 indefinitely.
//     -> flush_pc=1c000000 resumes at 1c000000.
//  6. FETCH_WIDTH=4, flush to FFFFFFF8 -> lane_valid=4'b0011, next req_pc=00000000.
//     Then rst mid-wait (req_ready=0) -> req_valid=0 next cycle, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// Fetch-PC generator: issues one block of FETCH_WIDTH sequential instruction PCs per
// valid/ready transfer, with block alignment, predicted/flush redirect and ADEF halt.

`ifndef EXCEPTION_ADEF
`define EXCEPTION_ADEF 7'h08
`endif
`ifndef EXCEPTION_NOP
`define EXCEPTION_NOP 7'h00
`endif

module fetch_pc_lane #(
    parameter int LANE        = 0,
    parameter int FETCH_WIDTH = 2,
    parameter int OFF_W       = 1
) (
    input  logic [31:0]      base_pc,
    input  logic [OFF_W-1:0] off,
    input  logic             active,
    input  logic             adef,
    output logic [31:0]      pc,
    output logic             valid
);
    assign pc = base_pc + 32'(4 * LANE);

    // A misaligned block carries only the faulting lane; otherwise lanes past the
    // end of the aligned block belong to the next fetch.
    always_comb begin
        valid = 1'b0;
        if (active) begin
            if (adef) valid = (LANE == 0);
            else      valid = (LANE + int'(off)) < FETCH_WIDTH;
        end
    end
endmodule

module fetch_pc_gen #(
    parameter int          FETCH_WIDTH = 2,
    parameter logic [31:0] RESET_PC    = 32'h1c000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [31:0]              flush_pc,
    input  logic                     stall,
    input  logic                     pred_taken,
    input  logic [31:0]              pred_pc,
    output logic                     req_valid,
    input  logic                     req_ready,
    output logic [31:0]              req_pc,
    output logic [32*FETCH_WIDTH-1:0] lane_pc,
    output logic [FETCH_WIDTH-1:0]   lane_valid,
    output logic                     pc_is_exception,
    output logic [6:0]               pc_exception_cause
);
    localparam int          BLK_BYTES = FETCH_WIDTH * 4;
    localparam int          OFF_W     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam logic [31:0] BLK_MASK  = ~(32'(BLK_BYTES) - 32'd1);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t           state, state_nxt;
    logic [31:0]      pc, pc_nxt, seq_pc;
    logic [OFF_W-1:0] off;
    logic             active, adef, xfer;

    assign active    = (state == RUN);
    assign adef      = (pc[1:0] != 2'b00);
    assign req_valid = active & ~stall;
    assign xfer      = req_valid & req_ready;
    assign seq_pc    = (pc & BLK_MASK) + 32'(BLK_BYTES);

    generate
        if (FETCH_WIDTH > 1) begin : g_off
            assign off = pc[OFF_W+1:2];
        end else begin : g_off0
            assign off = '0;
        end
    endgenerate

    // Flush outranks a same-cycle transfer; the block just handed over is dropped downstream.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (xfer && adef) state_nxt = HALT;
            default: state_nxt = state;
        endcase
        if (xfer) pc_nxt = pred_taken ? pred_pc : seq_pc;
        if (flush) begin
            state_nxt = RUN;
            pc_nxt    = flush_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    assign req_pc             = pc;
    assign pc_is_exception    = active & adef;
    assign pc_exception_cause = pc_is_exception ? `EXCEPTION_ADEF : `EXCEPTION_NOP;

    generate
        for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
            fetch_pc_lane #(
                .LANE       (i),
                .FETCH_WIDTH(FETCH_WIDTH),
                .OFF_W      (OFF_W)
            ) u_lane (
                .base_pc(pc),
                .off    (off),
                .active (active),
                .adef   (adef),
                .pc     (lane_pc[32*i +: 32]),
                .valid  (lane_valid[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Drives FETCH_WIDTH=2 and =4 instances with shared stimulus; a behavioural model
// queues expected outputs per cycle and a negedge monitor compares them.

module tb_fetch_pc_gen;
    localparam logic [31:0] RST_PC = 32'h1c000000;
    localparam logic [6:0]  ADEF   = 7'h08;
    localparam logic [6:0]  NOP    = 7'h00;

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, stall = 1'b0, pred_taken = 1'b0, req_ready = 1'b0;
    logic [31:0]  flush_pc = '0, pred_pc = '0;
    logic         rv2, rv4, x2, x4;
    logic [31:0]  rp2, rp4;
    logic [63:0]  lp2;
    logic [127:0] lp4;
    logic [1:0]   lv2;
    logic [3:0]   lv4;
    logic [6:0]   c2, c4;

    always #5 clk = ~clk;

    fetch_pc_gen #(.FETCH_WIDTH(2), .RESET_PC(RST_PC)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc), .stall(stall),
        .pred_taken(pred_taken), .pred_pc(pred_pc), .req_valid(rv2), .req_ready(req_ready),
        .req_pc(rp2), .lane_pc(lp2), .lane_valid(lv2), .pc_is_exception(x2),
        .pc_exception_cause(c2));

    fetch_pc_gen #(.FETCH_WIDTH(4), .RESET_PC(RST_PC)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc), .stall(stall),
        .pred_taken(pred_taken), .pred_pc(pred_pc), .req_valid(rv4), .req_ready(req_ready),
        .req_pc(rp4), .lane_pc(lp4), .lane_valid(lv4), .pc_is_exception(x4),
        .pc_exception_cause(c4));

    typedef struct packed {
        logic         rv2, rv4, x2, x4;
        logic [31:0]  pc2, pc4;
        logic [1:0]   lv2;
        logic [3:0]   lv4;
        logic [63:0]  lp2;
        logic [127:0] lp4;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0, n_err = 0;
    logic [1:0]  ms[2];    // model state: 0 boot, 1 run, 2 halt
    logic [31:0] mpc[2];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_lv(input int w, input logic [1:0] st, input logic [31:0] pc);
        logic [3:0]  lv;
        logic [32:0] lim;
        lv = '0;
        if (st != 2'd1) return lv;
        if (pc[1:0] != 2'b00) return 4'b0001;
        lim = {1'b0, pc - (pc % 32'(4 * w))} + 33'(4 * w);
        for (int i = 0; i < w; i++)
            if (({1'b0, pc} + 33'(4 * i)) < lim) lv[i] = 1'b1;
        return lv;
    endfunction

    function automatic logic [127:0] m_lp(input int w, input logic [31:0] pc);
        logic [127:0] lp;
        lp = '0;
        for (int i = 0; i < w; i++) lp[32*i +: 32] = pc + 32'(4 * i);
        return lp;
    endfunction

    task automatic m_step();
        for (int k = 0; k < 2; k++) begin
            logic [1:0]  ns;
            logic [31:0] np, w4;
            logic        x;
            w4 = (k == 0) ? 32'd8 : 32'd16;
            x  = (ms[k] == 2'd1) && !stall && req_ready;
            ns = ms[k];
            np = mpc[k];
            if (ms[k] == 2'd0) ns = 2'd1;
            if (x) begin
                np = pred_taken ? pred_pc : (mpc[k] - (mpc[k] % w4)) + w4;
                if (mpc[k][1:0] != 2'b00) ns = 2'd2;
            end
            if (flush) begin ns = 2'd1; np = flush_pc; end
            if (rst)   begin ns = 2'd0; np = RST_PC;   end
            ms[k]  = ns;
            mpc[k] = np;
        end
    endtask

    task automatic push_exp();
        exp_t         e;
        logic [3:0]   t;
        logic [127:0] l;
        e.rv2 = (ms[0] == 2'd1) && !stall;
        e.rv4 = (ms[1] == 2'd1) && !stall;
        e.x2  = (ms[0] == 2'd1) && (mpc[0][1:0] != 2'b00);
        e.x4  = (ms[1] == 2'd1) && (mpc[1][1:0] != 2'b00);
        e.pc2 = mpc[0];
        e.pc4 = mpc[1];
        t = m_lv(2, ms[0], mpc[0]); e.lv2 = t[1:0];
        e.lv4 = m_lv(4, ms[1], mpc[1]);
        l = m_lp(2, mpc[0]); e.lp2 = l[63:0];
        e.lp4 = m_lp(4, mpc[1]);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rv2", 128'(rv2), 128'(e.rv2));
            check("pc2", 128'(rp2), 128'(e.pc2));
            check("lv2", 128'(lv2), 128'(e.lv2));
            check("lp2", 128'(lp2), 128'(e.lp2));
            check("x2",  128'(x2),  128'(e.x2));
            check("c2",  128'(c2),  128'(e.x2 ? ADEF : NOP));
            check("rv4", 128'(rv4), 128'(e.rv4));
            check("pc4", 128'(rp4), 128'(e.pc4));
            check("lv4", 128'(lv4), 128'(e.lv4));
            check("lp4", lp4, e.lp4);
            check("x4",  128'(x4),  128'(e.x4));
            check("c4",  128'(c4),  128'(e.x4 ? ADEF : NOP));
        end
    end

    // Inputs set here apply to the edge that ends the cycle being observed.
    task automatic cyc(input logic r, input logic fl, input logic [31:0] fpc, input logic st,
                       input logic pt, input logic [31:0] ppc, input logic rdy);
        @(posedge clk);
        m_step();
        #1;
        rst = r; flush = fl; flush_pc = fpc; stall = st;
        pred_taken = pt; pred_pc = ppc; req_ready = rdy;
        push_exp();
        #1;
    endtask

    task automatic run(input logic rdy);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, rdy);
    endtask

    task automatic redirect(input logic [31:0] fpc);
        cyc(1'b0, 1'b1, fpc, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        ms[0] = 2'd0; ms[1] = 2'd0; mpc[0] = RST_PC; mpc[1] = RST_PC;

        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("rst_rv",    128'(rv2), 128'(1'b0));
        check("rst_pc",    128'(rp2), 128'(RST_PC));
        check("rst_lv",    128'(lv2), 128'(2'b00));
        check("rst_exc",   128'(x2),  128'(1'b0));
        check("rst_cause", 128'(c2),  128'(NOP));
        check("rst_rv4",   128'(rv4), 128'(1'b0));

        run(1'b1); check("boot_rv", 128'(rv2), 128'(1'b0));
        run(1'b1); check("t1_rv", 128'(rv2), 128'(1'b1));
                   check("t1_pc0", 128'(rp2), 128'(32'h1c000000));
                   check("t1_lv", 128'(lv2), 128'(2'b11));
        run(1'b1); check("t1_pc1", 128'(rp2), 128'(32'h1c000008));
        run(1'b0); check("t1_pc2", 128'(rp2), 128'(32'h1c000010));
        run(1'b0); run(1'b0);
        check("t3_hold_pc", 128'(rp2), 128'(32'h1c000010));
        check("t3_hold_rv", 128'(rv2), 128'(1'b1));

        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1c000200, 1'b1);
        check("stall_rv", 128'(rv2), 128'(1'b0));
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1c000200, 1'b1);
        check("stall_pc", 128'(rp2), 128'(32'h1c000010));
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1c000200, 1'b1);
        check("stall_pred_ign", 128'(rp2), 128'(32'h1c000010));
        cyc(1'b0, 1'b1, 32'h1c000040, 1'b0, 1'b1, 32'h1c000300, 1'b1);
        check("pred_pc", 128'(rp2), 128'(32'h1c000200));
        run(1'b1); check("flush_over_pred", 128'(rp2), 128'(32'h1c000040));

        redirect(32'h1c000104);
        run(1'b1); check("unal_pc", 128'(rp2), 128'(32'h1c000104));
                   check("unal_lv", 128'(lv2), 128'(2'b01));
                   check("unal_lane0", 128'(lp2[31:0]), 128'(32'h1c000104));
        run(1'b1); check("unal_next", 128'(rp2), 128'(32'h1c000108));
                   check("unal_next_lv", 128'(lv2), 128'(2'b11));

        redirect(32'h1c000002);
        run(1'b1); check("adef_rv", 128'(rv2), 128'(1'b1));
                   check("adef_exc", 128'(x2), 128'(1'b1));
                   check("adef_cause", 128'(c2), 128'(ADEF));
                   check("adef_lv", 128'(lv2), 128'(2'b01));
        run(1'b1); check("halt_rv", 128'(rv2), 128'(1'b0));
        run(1'b1); run(1'b1);
        check("halt_stay", 128'(rv2), 128'(1'b0));
        check("halt_lv",   128'(lv2), 128'(2'b00));
        check("halt_exc",  128'(x2),  128'(1'b0));
        redirect(32'h1c000000);
        run(1'b1); check("resume_pc", 128'(rp2), 128'(32'h1c000000));
                   check("resume_rv", 128'(rv2), 128'(1'b1));

        redirect(32'hfffffff8);
        run(1'b1); check("wrap_lv4", 128'(lv4), 128'(4'b0011));
                   check("wrap_lv2", 128'(lv2), 128'(2'b11));
        run(1'b0); check("wrap_pc4", 128'(rp4), 128'(32'h0));
                   check("wrap_pc2", 128'(rp2), 128'(32'h0));
        run(1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        run(1'b0); check("rst_mid_rv", 128'(rv4), 128'(1'b0));
                   check("rst_mid_pc", 128'(rp4), 128'(RST_PC));

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, p;
            a = $urandom; p = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(5) != 0) p[1:0] = 2'b00;
            if ($urandom_range(3) == 0) a = 32'hfffffff0 | (a & 32'hc);
            cyc(($urandom_range(60) == 0), ($urandom_range(6) == 0), a,
                ($urandom_range(4) == 0), ($urandom_range(2) == 0), p,
                ($urandom_range(3) != 0));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        check("sb_drained", 128'(sb.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
